// File: rtl/farmer_game.sv
// River-crossing game controller: holds the four bank positions, applies one
// move per accepted command and tracks win/loss and the number of moves made.
module farmer_game #(
  parameter int MOVE_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              restart,
  input  logic              move_valid,
  input  logic [1:0]        move_sel,
  output logic              f_out,
  output logic              x_out,
  output logic              g_out,
  output logic              b_out,
  output logic              e_out,
  output logic              illegal,
  output logic              win,
  output logic              lost,
  output logic [MOVE_W-1:0] move_count
);

  typedef enum logic [1:0] {PLAY, LOST, WON} state_t;

  state_t state;

  logic sel_bank;
  logic legal;
  logic next_f, next_x, next_g, next_b;

  // Goose is eaten (or eats) whenever it shares a bank with fox or beans
  // while the farmer is across the river.
  function automatic logic unsafe(input logic f, input logic x,
                                  input logic g, input logic b);
    return ((x == g) && (f != g)) || ((g == b) && (f != g));
  endfunction

  always_comb begin
    sel_bank = f_out;
    case (move_sel)
      2'd1:    sel_bank = x_out;
      2'd2:    sel_bank = g_out;
      2'd3:    sel_bank = b_out;
      default: sel_bank = f_out;
    endcase
  end

  assign legal  = (move_sel == 2'd0) || (sel_bank == f_out);
  assign next_f = ~f_out;
  assign next_x = x_out ^ (move_sel == 2'd1);
  assign next_g = g_out ^ (move_sel == 2'd2);
  assign next_b = b_out ^ (move_sel == 2'd3);

  assign e_out = unsafe(f_out, x_out, g_out, b_out);
  assign win   = (state == WON);
  assign lost  = (state == LOST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= PLAY;
      f_out      <= 1'b0;
      x_out      <= 1'b0;
      g_out      <= 1'b0;
      b_out      <= 1'b0;
      illegal    <= 1'b0;
      move_count <= '0;
    end else if (restart) begin
      state      <= PLAY;
      f_out      <= 1'b0;
      x_out      <= 1'b0;
      g_out      <= 1'b0;
      b_out      <= 1'b0;
      illegal    <= 1'b0;
      move_count <= '0;
    end else begin
      illegal <= 1'b0;
      if ((state == PLAY) && move_valid) begin
        if (legal) begin
          f_out <= next_f;
          x_out <= next_x;
          g_out <= next_g;
          b_out <= next_b;
          if (move_count != '1)
            move_count <= move_count + MOVE_W'(1);
          // Outcome is judged on the position this move creates.
          if (unsafe(next_f, next_x, next_g, next_b))
            state <= LOST;
          else if (next_f && next_x && next_g && next_b)
            state <= WON;
          else
            state <= PLAY;
        end else begin
          illegal <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_farmer_game.sv
// Self-checking bench for farmer_game: directed game scenarios, a randomized
// command stream against a bank-array reference model, and counter saturation.
module tb_farmer_game;

  localparam int COUNT_MAX = 255;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       restart = 1'b0;
  logic       move_valid = 1'b0;
  logic [1:0] move_sel = 2'd0;
  logic       f_out, x_out, g_out, b_out, e_out, illegal, win, lost;
  logic [7:0] move_count;

  logic       sat_restart = 1'b0;
  logic       sat_move_valid = 1'b0;
  logic [1:0] sat_move_sel = 2'd0;
  logic       sat_f, sat_x, sat_g, sat_b, sat_e, sat_illegal, sat_win, sat_lost;
  logic [1:0] sat_count;

  int n_checks = 0;
  int n_fail = 0;

  // Reference model: index 0 farmer, 1 fox, 2 goose, 3 beans (matches move_sel).
  int m_pos[4];
  int m_count;
  string m_state;
  bit m_ill;

  farmer_game #(.MOVE_W(8)) dut (
    .clk(clk), .reset(reset), .restart(restart), .move_valid(move_valid),
    .move_sel(move_sel), .f_out(f_out), .x_out(x_out), .g_out(g_out),
    .b_out(b_out), .e_out(e_out), .illegal(illegal), .win(win), .lost(lost),
    .move_count(move_count)
  );

  farmer_game #(.MOVE_W(2)) dut_sat (
    .clk(clk), .reset(reset), .restart(sat_restart), .move_valid(sat_move_valid),
    .move_sel(sat_move_sel), .f_out(sat_f), .x_out(sat_x), .g_out(sat_g),
    .b_out(sat_b), .e_out(sat_e), .illegal(sat_illegal), .win(sat_win),
    .lost(sat_lost), .move_count(sat_count)
  );

  always #5 clk = ~clk;

  function automatic bit model_unsafe();
    bit goose_with_other;
    goose_with_other = (m_pos[1] == m_pos[2]) || (m_pos[2] == m_pos[3]);
    return goose_with_other && (m_pos[0] != m_pos[2]);
  endfunction

  task automatic model_reset();
    foreach (m_pos[i]) m_pos[i] = 0;
    m_count = 0;
    m_state = "play";
    m_ill = 0;
  endtask

  task automatic model_step(input bit rs, input bit mv, input int sel);
    m_ill = 0;
    if (rs) begin
      model_reset();
    end else if (mv && m_state == "play") begin
      if (sel != 0 && m_pos[sel] != m_pos[0]) begin
        m_ill = 1;
      end else begin
        m_pos[0] = 1 - m_pos[0];
        if (sel != 0) m_pos[sel] = 1 - m_pos[sel];
        if (m_count < COUNT_MAX) m_count++;
        if (model_unsafe()) m_state = "lost";
        else if (m_pos[0] + m_pos[1] + m_pos[2] + m_pos[3] == 4) m_state = "won";
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] model_pos();
    return 4'((m_pos[0] << 3) | (m_pos[1] << 2) | (m_pos[2] << 1) | m_pos[3]);
  endfunction

  task automatic check_output(input string label);
    check({label, "/pos"}, 32'({f_out, x_out, g_out, b_out}), 32'(model_pos()));
    check({label, "/e_out"}, 32'(e_out), 32'(model_unsafe()));
    check({label, "/illegal"}, 32'(illegal), 32'(m_ill));
    check({label, "/win"}, 32'(win), 32'(m_state == "won"));
    check({label, "/lost"}, 32'(lost), 32'(m_state == "lost"));
    check({label, "/count"}, 32'(move_count), 32'(m_count));
  endtask

  task automatic apply_stimulus(input bit rs, input bit mv, input int sel, input string label);
    restart = rs;
    move_valid = mv;
    move_sel = 2'(sel);
    @(posedge clk);
    model_step(rs, mv, sel);
    #1;
    restart = 1'b0;
    move_valid = 1'b0;
    check_output(label);
  endtask

  int opt_sel[7] = '{2, 0, 1, 2, 3, 0, 2};
  logic [3:0] opt_pos[7] = '{4'b1010, 4'b0010, 4'b1110, 4'b0100, 4'b1101, 4'b0101, 4'b1111};

  initial begin
    model_reset();
    #3;
    check_output("reset_held");
    #9 reset = 1'b0;
    for (int i = 0; i < 3; i++) apply_stimulus(0, 0, 0, "idle");

    // Optimal seven-move solution, checked against the known position table.
    for (int i = 0; i < 7; i++) begin
      apply_stimulus(0, 1, opt_sel[i], "optimal");
      check("optimal/table", 32'({f_out, x_out, g_out, b_out}), 32'(opt_pos[i]));
      check("optimal/no_e", 32'(e_out), 32'd0);
    end
    check("optimal/win", 32'(win), 32'd1);
    check("optimal/count", 32'(move_count), 32'd7);
    apply_stimulus(0, 1, 0, "won_ignore");
    apply_stimulus(0, 1, 2, "won_ignore");

    // Loss: fox crosses, goose left with beans.
    apply_stimulus(1, 0, 0, "restart");
    apply_stimulus(0, 1, 1, "loss");
    check("loss/pos", 32'({f_out, x_out, g_out, b_out}), 32'b1100);
    check("loss/lost", 32'(lost), 32'd1);
    apply_stimulus(0, 1, 0, "lost_ignore");
    apply_stimulus(1, 1, 2, "restart_from_lost");
    check("restart_from_lost/lost", 32'(lost), 32'd0);

    // Illegal move: beans on far side of the farmer.
    apply_stimulus(0, 1, 2, "ill_setup");
    apply_stimulus(0, 1, 3, "illegal");
    check("illegal/pulse", 32'(illegal), 32'd1);
    check("illegal/pos", 32'({f_out, x_out, g_out, b_out}), 32'b1010);
    apply_stimulus(0, 0, 0, "illegal_clear");
    check("illegal/clear", 32'(illegal), 32'd0);
    apply_stimulus(0, 1, 2, "goose_back");
    apply_stimulus(0, 1, 3, "beans_legal");

    // Restart priority mid-game.
    apply_stimulus(1, 0, 0, "restart");
    apply_stimulus(0, 1, 2, "mid_game");
    apply_stimulus(1, 1, 0, "restart_priority");
    check("restart_priority/pos", 32'({f_out, x_out, g_out, b_out}), 32'd0);

    // Asynchronous reset between edges.
    apply_stimulus(0, 1, 2, "pre_async");
    reset = 1'b1;
    #1;
    model_reset();
    check_output("async_reset");
    #2 reset = 1'b0;
    apply_stimulus(0, 1, 2, "post_async");

    // Randomized command stream.
    for (int i = 0; i < 400; i++) begin
      bit rs, mv;
      int sel;
      rs = ($urandom % 16) == 0;
      mv = ($urandom % 4) != 0;
      sel = int'($urandom % 4);
      apply_stimulus(rs, mv, sel, "random");
    end

    // Saturation on the two-bit counter instance with goose shuttles.
    for (int i = 1; i <= 5; i++) begin
      sat_move_valid = 1'b1;
      sat_move_sel = 2'd2;
      @(posedge clk);
      #1;
      sat_move_valid = 1'b0;
      check("sat/count", 32'(sat_count), 32'((i < 3) ? i : 3));
      check("sat/f", 32'(sat_f), 32'(i % 2));
      check("sat/g", 32'(sat_g), 32'(i % 2));
      check("sat/lost", 32'(sat_lost), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
